// File: rtl/cen_pkg.sv
// cen_pkg: shared state encoding and default sizes for the centering sequencer.
package cen_pkg;
    localparam int CEN_DATA_W = 26;
    localparam int CEN_LOG2_N = 10;
    localparam int CEN_ACC_W  = CEN_DATA_W + CEN_LOG2_N;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACC       = 3'd1,
        ST_ACC_DRAIN = 3'd2,
        ST_MEAN      = 3'd3,
        ST_SUB       = 3'd4,
        ST_SUB_DRAIN = 3'd5,
        ST_DONE      = 3'd6
    } cen_state_t;
endpackage

// File: rtl/cen_accum.sv
// cen_accum: four-lane clearable accumulator, wide enough that a full block never overflows.
module cen_accum
    import cen_pkg::*;
#(
    parameter int DATA_W = CEN_DATA_W,
    parameter int LOG2_N = CEN_LOG2_N,
    localparam int ACC_W = DATA_W + LOG2_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [DATA_W-1:0] x4,
    output logic [ACC_W-1:0]  acc1,
    output logic [ACC_W-1:0]  acc2,
    output logic [ACC_W-1:0]  acc3,
    output logic [ACC_W-1:0]  acc4
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            acc1 <= '0;
            acc2 <= '0;
            acc3 <= '0;
            acc4 <= '0;
        end else if (add_en) begin
            acc1 <= acc1 + ACC_W'(x1);
            acc2 <= acc2 + ACC_W'(x2);
            acc3 <= acc3 + ACC_W'(x3);
            acc4 <= acc4 + ACC_W'(x4);
        end
    end
endmodule

// File: rtl/cen_controller.sv
// cen_controller: two-pass sequencer (accumulate means, then replay through the subtractor).
// Define CEN_ROUND_EN for round-half-up means; default build truncates.
module cen_controller
    import cen_pkg::*;
#(
    parameter int DATA_W = CEN_DATA_W,
    parameter int LOG2_N = CEN_LOG2_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              GO,
    input  logic [DATA_W-1:0] x1_in,
    input  logic [DATA_W-1:0] x2_in,
    input  logic [DATA_W-1:0] x3_in,
    input  logic [DATA_W-1:0] x4_in,
    output logic              rd_en,
    output logic [LOG2_N-1:0] rd_addr,
    output logic              En,
    output logic [DATA_W-1:0] res1,
    output logic [DATA_W-1:0] res2,
    output logic [DATA_W-1:0] res3,
    output logic [DATA_W-1:0] res4,
    output logic              cen_valid,
    output logic [LOG2_N-1:0] cen_idx,
    output logic              busy,
    output logic              done
);
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST = '1;

    cen_state_t        r_state, w_next;
    logic [LOG2_N-1:0] r_addr, r_idx_d1, r_idx_d2;
    logic              r_drain, r_acc_v, r_en, r_valid;
    logic              w_reading, w_last;
    logic [ACC_W-1:0]  w_acc  [4];
    logic [DATA_W-1:0] w_mean [4];
    logic [DATA_W-1:0] r_res  [4];

    assign w_reading = (r_state == ST_ACC) || (r_state == ST_SUB);
    assign w_last    = r_addr == LAST;

    // Accumulators stay cleared whenever idle so every block starts from zero.
    cen_accum #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_accum (
        .clk    (clk),
        .rst    (rst),
        .clr    (r_state == ST_IDLE),
        .add_en (r_acc_v),
        .x1     (x1_in),
        .x2     (x2_in),
        .x3     (x3_in),
        .x4     (x4_in),
        .acc1   (w_acc[0]),
        .acc2   (w_acc[1]),
        .acc3   (w_acc[2]),
        .acc4   (w_acc[3])
    );

`ifdef CEN_ROUND_EN
    localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
`endif
    for (genvar g = 0; g < 4; g++) begin : g_mean
`ifdef CEN_ROUND_EN
        assign w_mean[g] = DATA_W'((w_acc[g] + HALF) >> LOG2_N);
`else
        assign w_mean[g] = DATA_W'(w_acc[g] >> LOG2_N);
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      w_next = GO ? ST_ACC : ST_IDLE;
            ST_ACC:       w_next = w_last ? ST_ACC_DRAIN : ST_ACC;
            ST_ACC_DRAIN: w_next = ST_MEAN;
            ST_MEAN:      w_next = ST_SUB;
            ST_SUB:       w_next = w_last ? ST_SUB_DRAIN : ST_SUB;
            ST_SUB_DRAIN: w_next = r_drain ? ST_DONE : ST_SUB_DRAIN;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Address wraps to 0 naturally on the N-1 exit and is held at 0 outside the read passes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_drain  <= 1'b0;
            r_acc_v  <= 1'b0;
            r_en     <= 1'b0;
            r_valid  <= 1'b0;
            r_idx_d1 <= '0;
            r_idx_d2 <= '0;
            for (int i = 0; i < 4; i++) r_res[i] <= '0;
        end else begin
            r_state  <= w_next;
            r_addr   <= w_reading ? r_addr + 1'b1 : '0;
            r_drain  <= (r_state == ST_SUB_DRAIN) && !r_drain;
            r_acc_v  <= r_state == ST_ACC;
            r_en     <= r_state == ST_SUB;
            r_valid  <= r_en;
            r_idx_d1 <= r_addr;
            r_idx_d2 <= r_idx_d1;
            if (r_state == ST_MEAN)
                for (int i = 0; i < 4; i++) r_res[i] <= w_mean[i];
        end
    end

    assign rd_en     = w_reading;
    assign rd_addr   = r_addr;
    assign En        = r_en;
    assign cen_valid = r_valid;
    assign cen_idx   = r_idx_d2;
    assign busy      = r_state != ST_IDLE;
    assign done      = r_state == ST_DONE;
    assign res1      = r_res[0];
    assign res2      = r_res[1];
    assign res3      = r_res[2];
    assign res4      = r_res[3];
endmodule

// File: tb/tb_cen_controller.sv
// tb_cen_controller: directed bench with a sample-memory model and a registered subtractor model.
module tb_cen_controller;
    localparam int DW = 26;
    localparam int LN = 2;
    localparam int N  = 4;
    localparam int LB = 10;

    logic          clk = 1'b0, rst = 1'b1, go = 1'b0, go_b = 1'b0;
    logic [DW-1:0] x_in [4];
    logic [DW-1:0] res  [4];
    logic [DW-1:0] xc   [4];
    logic          rd_en, en, cen_valid, busy, done;
    logic [LN-1:0] rd_addr, cen_idx;
    logic [DW-1:0] full = '1;
    logic [DW-1:0] res_b [4];
    logic          rd_en_b, en_b, cv_b, busy_b, done_b;
    logic [LB-1:0] rd_addr_b, ci_b;
    logic [DW-1:0] mem [8][4][N];
    int            blk = 0;
    int            n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    cen_controller #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .clk(clk), .rst(rst), .GO(go),
        .x1_in(x_in[0]), .x2_in(x_in[1]), .x3_in(x_in[2]), .x4_in(x_in[3]),
        .rd_en(rd_en), .rd_addr(rd_addr), .En(en),
        .res1(res[0]), .res2(res[1]), .res3(res[2]), .res4(res[3]),
        .cen_valid(cen_valid), .cen_idx(cen_idx), .busy(busy), .done(done)
    );

    cen_controller #(.DATA_W(DW), .LOG2_N(LB)) dut_fs (
        .clk(clk), .rst(rst), .GO(go_b),
        .x1_in(full), .x2_in(full), .x3_in(full), .x4_in(full),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .En(en_b),
        .res1(res_b[0]), .res2(res_b[1]), .res3(res_b[2]), .res4(res_b[3]),
        .cen_valid(cv_b), .cen_idx(ci_b), .busy(busy_b), .done(done_b)
    );

    // Sample memory with one cycle of read latency, and the downstream subtractor.
    always @(posedge clk) begin
        if (rd_en)
            for (int c = 0; c < 4; c++) x_in[c] <= mem[blk][c][rd_addr];
        if (en)
            for (int c = 0; c < 4; c++) xc[c] <= x_in[c] - res[c];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_mean(input int b, input int c);
        int s = 0;
        for (int a = 0; a < N; a++) s += int'(mem[b][c][a]);
`ifdef CEN_ROUND_EN
        s += N / 2;
`endif
        return DW'(s / N);
    endfunction

    task automatic set4(input int b, input int c, input int a0, input int a1, input int a2, input int a3);
        mem[b][c][0] = DW'(a0);
        mem[b][c][1] = DW'(a1);
        mem[b][c][2] = DW'(a2);
        mem[b][c][3] = DW'(a3);
    endtask

    // Starts a block from a negedge; p1/p2 are cycles at which a stray GO pulse is driven.
    task automatic run(input int ncyc, input int nblk, input bit hold, input int p1, input int p2);
        int nd = 0, nv = 0, ne = 0, fv = 0, fe = 0, last_d = 0;
        go = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("rd_en_c1", rd_en, 1);
                chk("rd_addr_c1", rd_addr, 0);
            end
            if (en) begin
                ne++;
                if (fe == 0) fe = k;
            end
            if (cen_valid) begin
                if (fv == 0) fv = k;
                chk("cen_idx", cen_idx, nv % N);
                for (int c = 0; c < 4; c++)
                    chk($sformatf("xcen%0d", c + 1), xc[c], DW'(mem[blk][c][nv % N] - exp_mean(blk, c)));
                nv++;
            end
            if (done) begin
                chk("done_gap", k - last_d, nd == 0 ? 2 * N + 5 : 2 * N + 6);
                for (int c = 0; c < 4; c++)
                    chk($sformatf("res%0d", c + 1), res[c], exp_mean(blk, c));
                last_d = k;
                nd++;
                blk++;
            end
            go = (hold && nd < nblk) || k == p1 || k == p2;
        end
        chk("done_count", nd, nblk);
        chk("valid_count", nv, N * nblk);
        chk("en_count", ne, N * nblk);
        chk("en_first", fe, N + 4);
        chk("valid_first", fv, N + 5);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        int k;
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < 4; c++) set4(b, c, 7, 7, 7, 7);
        set4(0, 0, 10, 20, 30, 40);
        set4(1, 0, 1, 2, 2, 2);
        set4(1, 1, 3, 4, 5, 6);
        set4(2, 0, 1000, 2000, 3000, 4000);
        set4(3, 0, 100, 200, 300, 400);
        set4(3, 2, 0, 0, 0, 4);
        set4(4, 0, 8, 8, 8, 8);
        set4(5, 0, 50, 60, 70, 80);
        set4(5, 3, 9, 9, 9, 10);
        set4(6, 0, 0, 0, 0, 0);
        set4(6, 3, 1, 2, 3, 4);
        for (int c = 0; c < 4; c++) x_in[c] = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", cen_valid, 0);
        chk("rst_res1", res[0], 0);
        rst = 1'b0;
        @(negedge clk);

        blk = 0;
        run(2 * N + 10, 1, 1'b0, 0, 0);
        chk("basic_res1", res[0], 25);
        chk("basic_res2", res[1], 7);

        blk = 1;
        run(30, 1, 1'b0, 2, N + 4);
`ifdef CEN_ROUND_EN
        chk("round_res1", res[0], 2);
`else
        chk("round_res1", res[0], 1);
`endif

        blk = 2;
        go = 1'b1;
        for (int j = 1; j <= N + 5; j++) begin
            @(negedge clk);
            go = 1'b0;
        end
        chk("pre_rst_valid", cen_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_rd_addr", rd_addr, 0);
        chk("mid_rst_en", en, 0);
        chk("mid_rst_valid", cen_valid, 0);
        chk("mid_rst_idx", cen_idx, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_res1", res[0], 0);
        chk("mid_rst_res4", res[3], 0);
        rst = 1'b0;
        @(negedge clk);
        blk = 3;
        run(2 * N + 10, 1, 1'b0, 0, 0);

        blk = 4;
        run(3 * (2 * N + 6) + 4, 3, 1'b1, 0, 0);

        go_b = 1'b1;
        for (k = 1; k <= 2 * (1 << LB) + 20; k++) begin
            @(negedge clk);
            go_b = 1'b0;
            if (done_b) break;
        end
        chk("fs_done_cycle", k, 2 * (1 << LB) + 5);
        for (int c = 0; c < 4; c++)
            chk($sformatf("fs_res%0d", c + 1), res_b[c], full);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
